// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package pipeline_pkg;

   localparam int DEFAULT_DATA_WIDTH    = 20;
   localparam int DEFAULT_ADDRESS_WIDTH = 8;
   localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_HALT_WORD = 20'hFFFFF;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_RUN,
      FS_HALT
   } fetch_state_t;

   // Default-width layout; the top re-declares it at its own parameter widths.
   typedef struct packed {
      logic [DEFAULT_ADDRESS_WIDTH-1:0] pc;
      logic [DEFAULT_DATA_WIDTH-1:0]    instruction;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_queue.sv
// Two-entry FIFO between fetch and decode; flush overrides push and pop.
module fetch_queue #(
   parameter int WIDTH = 28
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] slots [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = slots[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: payload storage is not reset; occupancy is tracked by count, so stale data is never observed.
   always_ff @(posedge clk) begin
      if (do_push && !flush) slots[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, fills the fetch queue, handles redirect and halt.
module fetch_controller
   import pipeline_pkg::*;
#(
   parameter int                      DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int                      ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int                      MEM_SIZE      = 256,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0,
   parameter logic [DATA_WIDTH-1:0]    HALT_WORD    = DATA_WIDTH'(DEFAULT_HALT_WORD)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic [ADDRESS_WIDTH-1:0] imem_address,
   input  logic [DATA_WIDTH-1:0]    imem_instruction,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   output logic                     if_valid,
   input  logic                     if_ready,
   output logic [DATA_WIDTH-1:0]    if_instruction,
   output logic [ADDRESS_WIDTH-1:0] if_pc,
   output logic                     halted,
   output logic                     error
);

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0]    instruction;
   } entry_t;

   localparam int                       ENTRY_WIDTH = $bits(entry_t);
   localparam logic [ADDRESS_WIDTH:0]   MEM_LIMIT   = (ADDRESS_WIDTH + 1)'(MEM_SIZE);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_PC     = ADDRESS_WIDTH'(MEM_SIZE - 1);

   fetch_state_t             state;
   fetch_state_t             next_state;
   logic [ADDRESS_WIDTH-1:0] pc;
   logic [ADDRESS_WIDTH-1:0] next_pc;
   logic                     next_error;
   logic                     push;
   logic                     pop;
   logic                     flush;
   logic                     full;
   logic                     empty;
   logic                     redirect_taken;
   logic                     redirect_bad;
   entry_t                   push_entry;
   entry_t                   head_entry;

   assign redirect_taken = redirect_valid && (state != FS_IDLE);
   assign redirect_bad   = ({1'b0, redirect_pc} >= MEM_LIMIT);
   assign flush          = redirect_taken;
   assign pop            = !empty && if_ready;
   assign push_entry     = '{pc: pc, instruction: imem_instruction};

   fetch_queue #(
      .WIDTH(ENTRY_WIDTH)
   ) u_queue (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .flush    (flush),
      .push_data(push_entry),
      .head     (head_entry),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      next_state = state;
      next_pc    = pc;
      next_error = error;
      push       = 1'b0;
      if (redirect_taken) begin
         if (redirect_bad) begin
            next_state = FS_HALT;
            next_error = 1'b1;
         end else begin
            next_state = FS_RUN;
            next_pc    = redirect_pc;
         end
      end else begin
         case (state)
            FS_IDLE: begin
               if (start) next_state = FS_RUN;
            end
            FS_RUN: begin
               if (!full || pop) begin
                  push = 1'b1;
                  // The last word stops fetch without advancing, so the PC never wraps.
                  if (pc == LAST_PC) begin
                     next_state = FS_HALT;
                  end else begin
                     next_pc = pc + ADDRESS_WIDTH'(1);
                     if (imem_instruction == HALT_WORD) next_state = FS_HALT;
                  end
               end
            end
            FS_HALT: begin
               next_state = FS_HALT;
            end
            default: begin
               next_state = FS_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FS_IDLE;
         pc    <= RESET_PC;
         error <= 1'b0;
      end else begin
         state <= next_state;
         pc    <= next_pc;
         error <= next_error;
      end
   end

   assign imem_address   = pc;
   assign halted         = (state == FS_HALT);
   assign if_valid       = !empty;
   assign if_pc          = empty ? '0 : head_entry.pc;
   assign if_instruction = empty ? '0 : head_entry.instruction;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus randomized traffic vs. a queue model.
module tb_fetch_controller;
   import pipeline_pkg::*;

   localparam int          AW       = 9;
   localparam int          DW       = 20;
   localparam int          MEM_SIZE = 256;
   localparam logic [19:0] HW       = 20'hFFFFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start;
   logic [AW-1:0] imem_address;
   logic [DW-1:0] imem_instruction;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          if_valid;
   logic          if_ready;
   logic [DW-1:0] if_instruction;
   logic [AW-1:0] if_pc;
   logic          halted;
   logic          error;

   logic          start_b;
   logic [7:0]    imem_address_b;
   logic [DW-1:0] imem_instruction_b;
   logic          redirect_valid_b;
   logic [7:0]    redirect_pc_b;
   logic          if_valid_b;
   logic          if_ready_b;
   logic [DW-1:0] if_instruction_b;
   logic [7:0]    if_pc_b;
   logic          halted_b;
   logic          error_b;

   logic [DW-1:0] mem [0:511];

   assign imem_instruction   = mem[imem_address];
   assign imem_instruction_b = mem[{1'b0, imem_address_b}];

   always #5 clk = ~clk;

   fetch_controller #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MEM_SIZE), .RESET_PC(9'h000), .HALT_WORD(HW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .imem_address(imem_address),
      .imem_instruction(imem_instruction), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
      .if_instruction(if_instruction), .if_pc(if_pc), .halted(halted), .error(error)
   );

   fetch_controller #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(8), .MEM_SIZE(256), .RESET_PC(8'hFD), .HALT_WORD(HW)
   ) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .imem_address(imem_address_b),
      .imem_instruction(imem_instruction_b), .redirect_valid(redirect_valid_b),
      .redirect_pc(redirect_pc_b), .if_valid(if_valid_b), .if_ready(if_ready_b),
      .if_instruction(if_instruction_b), .if_pc(if_pc_b), .halted(halted_b), .error(error_b)
   );

   // Reference model: fetch queue as a list of {pc, word}, plus mode, PC and sticky error.
   typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
   typedef struct {
      int            pc;
      logic [DW-1:0] instr;
   } ent_t;

   ent_t  mq[$];
   int    m_pc;
   mode_t m_mode;
   bit    m_err;
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      w = DW'($urandom);
      if (w == HW) w = '0;
      return w;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pc   = 0;
      m_mode = M_IDLE;
      m_err  = 1'b0;
   endtask

   task automatic model_step(input logic st, input logic rv, input logic [AW-1:0] rpc, input logic rdy);
      ent_t e;
      if (m_mode == M_IDLE) begin
         if (st) m_mode = M_RUN;
         return;
      end
      if (rv) begin
         mq.delete();
         if (int'(rpc) >= MEM_SIZE) begin
            m_mode = M_HALT;
            m_err  = 1'b1;
         end else begin
            m_mode = M_RUN;
            m_pc   = int'(rpc);
         end
         return;
      end
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (m_mode == M_RUN && mq.size() < 2) begin
         e.pc    = m_pc;
         e.instr = mem[m_pc];
         mq.push_back(e);
         if (m_pc == MEM_SIZE - 1) begin
            m_mode = M_HALT;
         end else begin
            m_pc++;
            if (e.instr == HW) m_mode = M_HALT;
         end
      end
   endtask

   task automatic compare_outputs();
      check("if_valid", if_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         check("if_pc", if_pc, mq[0].pc);
         check("if_instruction", if_instruction, mq[0].instr);
      end
      check("halted", halted, m_mode == M_HALT);
      check("error", error, m_err);
      check("imem_address", imem_address, m_pc);
   endtask

   task automatic cycle(input logic st, input logic rv, input logic [AW-1:0] rpc, input logic rdy);
      start          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if_ready       = rdy;
      model_step(st, rv, rpc, rdy);
      @(posedge clk);
      #1;
      start          = 1'b0;
      redirect_valid = 1'b0;
      compare_outputs();
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      start          = 1'b0;
      redirect_valid = 1'b0;
      start_b        = 1'b0;
      #1;
      check("rst_if_valid", if_valid, 0);
      check("rst_if_pc", if_pc, 0);
      check("rst_if_instruction", if_instruction, 0);
      check("rst_halted", halted, 0);
      check("rst_error", error, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      compare_outputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int   got_b[$];
      logic wrapped;

      start = 0; redirect_valid = 0; redirect_pc = '0; if_ready = 0;
      start_b = 0; redirect_valid_b = 0; redirect_pc_b = '0; if_ready_b = 1;
      for (int i = 0; i < 512; i++) mem[i] = rand_word();
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Straight-line fetch ending on a halt word.
      mem[0] = 20'h0000A; mem[1] = 20'h0000B; mem[2] = 20'h0000C; mem[3] = HW;
      cycle(1, 0, '0, 1);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, '0, 1);
         check("t1_valid", if_valid, 1);
         check("t1_pc", if_pc, i);
      end
      check("t1_halted", halted, 1);
      check("t1_pc_reg", imem_address, 4);
      cycle(0, 0, '0, 1);
      check("t1_drained", if_valid, 0);
      mem[3] = rand_word();

      // Backpressure: queue fills to two entries and releases in order.
      do_reset();
      cycle(1, 0, '0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, '0, 0);
      check("t2_valid", if_valid, 1);
      check("t2_head_pc", if_pc, 0);
      check("t2_pc_reg", imem_address, 2);
      for (int k = 0; k < 4; k++) begin
         check("t2_order", if_pc, k);
         cycle(0, 0, '0, 1);
      end

      // Redirect with a full queue while decode is popping.
      cycle(0, 1, 9'h040, 1);
      check("t3_flushed", if_valid, 0);
      cycle(0, 0, '0, 1);
      check("t3_valid", if_valid, 1);
      check("t3_pc", if_pc, 9'h040);

      // Out-of-range redirect, then recovery.
      cycle(0, 1, 9'h100, 0);
      check("t5_halted", halted, 1);
      check("t5_error", error, 1);
      check("t5_empty", if_valid, 0);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);
      check("t5_still_halted", halted, 1);
      check("t5_no_fetch", if_valid, 0);
      cycle(0, 1, 9'h010, 0);
      check("t5_run", halted, 0);
      check("t5_error_sticky", error, 1);
      cycle(0, 0, '0, 0);
      check("t5_pc", if_pc, 9'h010);

      // Reset with entries queued, then redirect while idle is ignored.
      cycle(0, 0, '0, 0);
      check("t6_queued", if_valid, 1);
      do_reset();
      check("t6_pc_reset", imem_address, 0);
      cycle(0, 1, 9'h020, 1);
      cycle(0, 0, '0, 1);
      check("t6_idle_valid", if_valid, 0);
      check("t6_idle_pc", imem_address, 0);

      // End of memory on an 8-bit PC starting at 0xFD.
      got_b.delete();
      wrapped = 1'b0;
      start_b = 1'b1;
      cycle(0, 0, '0, 0);
      start_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, '0, 0);
         if (if_valid_b) got_b.push_back(int'(if_pc_b));
         if (imem_address_b == 8'h00) wrapped = 1'b1;
      end
      check("t4_count", got_b.size(), 3);
      for (int j = 0; j < 3; j++)
         check("t4_pc", (j < got_b.size()) ? got_b[j] : -1, 8'hFD + j);
      check("t4_halted", halted_b, 1);
      check("t4_pc_reg", imem_address_b, 8'hFF);
      check("t4_no_wrap", wrapped, 0);
      check("t4_error", error_b, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 512; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HW : rand_word();
      do_reset();
      cycle(1, 0, '0, 1);
      for (int c = 0; c < 3000; c++) begin
         logic          st;
         logic          rv;
         logic          rdy;
         logic [AW-1:0] rpc;
         int            sel;
         st  = ($urandom_range(0, 19) == 0);
         rv  = ($urandom_range(0, 11) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         sel = $urandom_range(0, 19);
         if (sel < 14)      rpc = AW'($urandom_range(0, 255));
         else if (sel < 17) rpc = AW'($urandom_range(240, 255));
         else               rpc = AW'($urandom_range(256, 511));
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
            cycle(1, 0, '0, 1);
         end else begin
            cycle(st, rv, rpc, rdy);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
